dark_mem_arbiter: RTL and testbench
===================================

DARK_MEM_ARBITER -- requirements
Module: dark_mem_arbiter

Interface
REQ-001 SHALL have parameter NCORES, default 4: number of requesting cores, 1..16.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width, multiple of 8; byte-enable width BW=DW/8.
REQ-004 SHALL have parameter MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255: max wait cycles for MEM_VALID; 0 disables the timeout.
REQ-006 SHALL have parameter ERRDATA, default 32'hDEADBEEF (DW bits): read data returned on timeout.
REQ-007 CLK  in  1  sole clock, all state on rising edge.
REQ-008 RESn  in  1  asynchronous, active-low reset.
REQ-009 DADDR  in  AW*NCORES  per-core address, core i at [AW*i +: AW].
REQ-010 DATAO  in  DW*NCORES  per-core write data.
REQ-011 WR, RD  in  NCORES each  per-core write/read request, level, held until released.
REQ-012 BE  in  BW*NCORES  per-core byte enables.
REQ-013 DATAI  out  DW  registered read data for the released core.
REQ-014 HLT  out  NCORES  per-core stall.
REQ-015 ERR  out  NCORES  one-cycle pulse, coincident with release, on timeout.
REQ-016 GNT  out  log2(NCORES) (min 1)  index of current or last granted core.
REQ-017 REF_ADDR/REF_DATA/REF_BE  out  AW/DW/BW  registered memory command.
REQ-018 REF_RD, REF_WR, REF_VALID  out  1 each  command type and valid.
REQ-019 MEM_READY  in  1  memory accepts command when REF_VALID&MEM_READY.
REQ-020 MEM_VALID, MEM_DATA  in  1/DW  response strobe and read data.

Function
REQ-021 SHALL implement FSM IDLE, ISSUE, WAIT, RELEASE.
REQ-022 IDLE: if SEIZE=WR|RD nonzero, select one core, latch its ADDR/DATAO/BE/RD/WR into REF_*, set REF_VALID=1, go ISSUE; else stay.
REQ-023 Selection MODE=0: lowest set index of SEIZE.
REQ-024 Selection MODE=1: first set index at or above pointer PTR, wrapping modulo NCORES; after grant PTR <= grant+1 (NCORES-1 wraps to 0).
REQ-025 Selection SHALL be combinational on SEIZE and PTR, registered into GNT in the same edge.
REQ-026 ISSUE: hold REF_VALID and command stable until MEM_READY=1; on that edge REF_VALID<=0, go WAIT.
REQ-027 WAIT: on MEM_VALID=1 latch DATAI<=MEM_DATA (reads; writes latch too, ignored), clear REF_RD/REF_WR, go RELEASE.
REQ-028 WAIT timeout: counter cleared entering WAIT, incremented per WAIT cycle; when it reaches TIMEOUT with no MEM_VALID, DATAI<=ERRDATA, ERR[GNT] pulses in RELEASE, go RELEASE.
REQ-029 MEM_VALID and timeout in the same cycle: MEM_VALID wins, no ERR.
REQ-030 MEM_VALID in ISSUE or IDLE SHALL be ignored.
REQ-031 RELEASE: exactly one cycle, REL one-hot at GNT; next state IDLE.
REQ-032 HLT = SEIZE & ~REL, combinational; non-requesting cores never stalled.
REQ-033 Request-to-release latency: 1 (IDLE) + ISSUE cycles (>=1) + WAIT cycles (>=1) + 1 RELEASE; minimum 4 cycles with MEM_READY=1 and MEM_VALID one cycle after acceptance.
REQ-034 A core dropping its request before release SHALL not abort the transaction; it completes and is discarded.
REQ-035 Requests arriving during ISSUE/WAIT/RELEASE SHALL wait; no back-to-back grant without passing IDLE.
REQ-036 Round-robin SHALL guarantee each continuously requesting core a grant within NCORES transactions.

Reset
REQ-037 RESn=0 SHALL asynchronously force state IDLE, PTR=0, GNT=0, REL=0, ERR=0, REF_VALID=REF_RD=REF_WR=0, REF_ADDR/DATA/BE=0, DATAI=0, timeout counter 0.
REQ-038 Reset mid-transaction SHALL abandon it; after RESn rises, arbitration restarts from PTR=0 with no residual REF_VALID.

Verification
REQ-039 NCORES=4, MODE=1, RD=4'b1111 held, MEM_READY=1, MEM_VALID one cycle later -> grants in order 0,1,2,3,0; each release 4 cycles apart.
REQ-040 MODE=0, RD=4'b1010 held -> core 1 granted every transaction, core 3 HLT stays 1.
REQ-041 Core 2 WR, DADDR=0x100, DATAO=0x12345678, BE=4'hF, MEM_READY low 3 cycles -> REF_VALID held 4 cycles with command stable, then RELEASE with HLT[2]=0 one cycle.
REQ-042 TIMEOUT=8, core 0 RD, MEM_VALID never -> after 8 WAIT cycles DATAI=0xDEADBEEF, ERR[0]=1 one cycle, HLT[0]=0 same cycle.
REQ-043 RESn pulsed low during WAIT -> all outputs zero immediately; after release a new RD from core 3 gets granted with GNT=3, PTR then 0.
REQ-044 MEM_VALID and timeout coincide (MEM_VALID on 8th WAIT cycle, TIMEOUT=8), MEM_DATA=0xA5A5A5A5 -> DATAI=0xA5A5A5A5, ERR=0.

Source files
------------

// File: rtl/dark_mem_arbiter.sv
// Arbitrates per-core memory requests onto a single memory command port.
// Fixed-priority or round-robin selection, one transaction in flight, optional response timeout.
module dark_mem_arbiter #(
    parameter int unsigned   NCORES  = 4,
    parameter int unsigned   AW      = 32,
    parameter int unsigned   DW      = 32,
    parameter int unsigned   MODE    = 1,
    parameter int unsigned   TIMEOUT = 255,
    parameter logic [DW-1:0] ERRDATA = DW'(32'hDEADBEEF)
) (
    input  logic                                        CLK,
    input  logic                                        RESn,
    input  logic [AW*NCORES-1:0]                        DADDR,
    input  logic [DW*NCORES-1:0]                        DATAO,
    input  logic [NCORES-1:0]                           WR,
    input  logic [NCORES-1:0]                           RD,
    input  logic [(DW/8)*NCORES-1:0]                    BE,
    output logic [DW-1:0]                               DATAI,
    output logic [NCORES-1:0]                           HLT,
    output logic [NCORES-1:0]                           ERR,
    output logic [((NCORES > 1) ? $clog2(NCORES) : 1)-1:0] GNT,
    output logic [AW-1:0]                               REF_ADDR,
    output logic [DW-1:0]                               REF_DATA,
    output logic [DW/8-1:0]                             REF_BE,
    output logic                                        REF_RD,
    output logic                                        REF_WR,
    output logic                                        REF_VALID,
    input  logic                                        MEM_READY,
    input  logic                                        MEM_VALID,
    input  logic [DW-1:0]                               MEM_DATA
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned GW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned SW = GW + 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gnt_d;
    logic [AW-1:0]     addr_d;
    logic [DW-1:0]     data_d;
    logic [BW-1:0]     be_d;
    logic              rd_d, wr_d, valid_d;
    logic [DW-1:0]     datai_d;
    logic [NCORES-1:0] err_d;

    logic [NCORES-1:0] seize, rel, rot;
    logic [GW-1:0]     off, sel;
    logic [SW-1:0]     sum;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [BW-1:0]     sel_be;

    assign seize = WR | RD;
    assign rel   = (state_q == S_RELEASE) ? (NCORES'(1) << GNT) : '0;
    assign HLT   = seize & ~rel;

    // Winner selection: rotate requests so the pointer sits at bit 0, pick the lowest set bit.
    always_comb begin
        rot = NCORES'({seize, seize} >> ptr_q);
        off = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (rot[i]) off = GW'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= SW'(NCORES)) sum = sum - SW'(NCORES);
        sel = sum[GW-1:0];
        if (MODE == 0) begin
            sel = '0;
            for (int i = NCORES - 1; i >= 0; i--) begin
                if (seize[i]) sel = GW'(i);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_be   = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (sel == GW'(i)) begin
                sel_addr = DADDR[AW*i +: AW];
                sel_data = DATAO[DW*i +: DW];
                sel_be   = BE[BW*i +: BW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = GNT;
        addr_d  = REF_ADDR;
        data_d  = REF_DATA;
        be_d    = REF_BE;
        rd_d    = REF_RD;
        wr_d    = REF_WR;
        valid_d = REF_VALID;
        datai_d = DATAI;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|seize) begin
                    gnt_d   = sel;
                    ptr_d   = (sel == GW'(NCORES - 1)) ? '0 : GW'(sel + 1'b1);
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    be_d    = sel_be;
                    rd_d    = RD[sel];
                    wr_d    = WR[sel];
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (MEM_READY) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (MEM_VALID) begin
                    datai_d = MEM_DATA;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_RELEASE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    datai_d = ERRDATA;
                    err_d   = NCORES'(1) << GNT;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            GNT       <= '0;
            REF_ADDR  <= '0;
            REF_DATA  <= '0;
            REF_BE    <= '0;
            REF_RD    <= 1'b0;
            REF_WR    <= 1'b0;
            REF_VALID <= 1'b0;
            DATAI     <= '0;
            ERR       <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            GNT       <= gnt_d;
            REF_ADDR  <= addr_d;
            REF_DATA  <= data_d;
            REF_BE    <= be_d;
            REF_RD    <= rd_d;
            REF_WR    <= wr_d;
            REF_VALID <= valid_d;
            DATAI     <= datai_d;
            ERR       <= err_d;
        end
    end

endmodule

// File: tb/tb_dark_mem_arbiter.sv
// Scoreboard bench for dark_mem_arbiter: round-robin/timeout instance plus a fixed-priority instance.
module tb_dark_mem_arbiter;

    typedef struct {
        int          core;
        logic [31:0] data;
        logic [3:0]  err;
        int          gap;
    } exp_t;

    logic         CLK, RESn;
    logic [127:0] daddr, datao;
    logic [3:0]   wr, rd;
    logic [15:0]  be;
    logic [31:0]  datai, ref_addr, ref_data, mem_data;
    logic [3:0]   hlt, err, ref_be;
    logic [1:0]   gnt;
    logic         ref_rd, ref_wr, ref_valid, mem_ready, mem_valid;

    logic [127:0] fx_daddr, fx_datao;
    logic [3:0]   fx_wr, fx_rd;
    logic [15:0]  fx_be;
    logic [31:0]  fx_datai, fx_ref_addr, fx_ref_data, fx_mem_data;
    logic [3:0]   fx_hlt, fx_err, fx_ref_be;
    logic [1:0]   fx_gnt;
    logic         fx_ref_rd, fx_ref_wr, fx_ref_valid, fx_mem_ready, fx_mem_valid;

    exp_t q[$];
    exp_t fq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   resp_delay;
    logic [31:0] resp_xor;
    logic acc_flag, fx_acc;

    dark_mem_arbiter #(.NCORES(4), .AW(32), .DW(32), .MODE(1), .TIMEOUT(8)) u_dut (
        .CLK(CLK), .RESn(RESn), .DADDR(daddr), .DATAO(datao), .WR(wr), .RD(rd), .BE(be),
        .DATAI(datai), .HLT(hlt), .ERR(err), .GNT(gnt), .REF_ADDR(ref_addr),
        .REF_DATA(ref_data), .REF_BE(ref_be), .REF_RD(ref_rd), .REF_WR(ref_wr),
        .REF_VALID(ref_valid), .MEM_READY(mem_ready), .MEM_VALID(mem_valid), .MEM_DATA(mem_data)
    );

    dark_mem_arbiter #(.NCORES(4), .AW(32), .DW(32), .MODE(0), .TIMEOUT(8)) u_fix (
        .CLK(CLK), .RESn(RESn), .DADDR(fx_daddr), .DATAO(fx_datao), .WR(fx_wr), .RD(fx_rd),
        .BE(fx_be), .DATAI(fx_datai), .HLT(fx_hlt), .ERR(fx_err), .GNT(fx_gnt),
        .REF_ADDR(fx_ref_addr), .REF_DATA(fx_ref_data), .REF_BE(fx_ref_be), .REF_RD(fx_ref_rd),
        .REF_WR(fx_ref_wr), .REF_VALID(fx_ref_valid), .MEM_READY(fx_mem_ready),
        .MEM_VALID(fx_mem_valid), .MEM_DATA(fx_mem_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit fx, input int core, input logic [31:0] data,
                        input logic [3:0] e, input int gap);
        exp_t x;
        x.core = core; x.data = data; x.err = e; x.gap = gap;
        if (fx) fq.push_back(x);
        else    q.push_back(x);
    endtask

    task automatic wait_q(input bit fx, input int budget, input string name);
        int n = 0;
        while (((fx ? fq.size() : q.size()) != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(name, 64'(fx ? fq.size() : q.size()), 64'd0);
        if (fx) fq.delete();
        else    q.delete();
    endtask

    // Memory model: acceptance is seen at the edge, MEM_VALID lands in WAIT cycle resp_delay.
    always @(posedge CLK or negedge RESn) begin
        if (!RESn) acc_flag <= 1'b0;
        else       acc_flag <= ref_valid & mem_ready;
    end

    initial begin : responder
        int  k;
        bit  active;
        k = 0; active = 0;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge CLK);
            mem_valid = 1'b0;
            if (acc_flag) begin
                k = 1; active = 1;
            end else if (active) begin
                k++;
                if (k > 40) active = 0;
            end
            if (active && resp_delay > 0 && k == resp_delay) begin
                mem_valid = 1'b1;
                mem_data  = ref_addr ^ resp_xor;
                active    = 0;
            end
        end
    end

    always @(posedge CLK or negedge RESn) begin
        if (!RESn) fx_acc <= 1'b0;
        else       fx_acc <= fx_ref_valid & fx_mem_ready;
    end

    initial begin
        fx_mem_valid = 1'b0;
        forever begin
            @(negedge CLK);
            fx_mem_valid = fx_acc;
        end
    end

    // Release monitor: a requesting core whose HLT drops is the one being released.
    initial begin : mon
        int          last_rel;
        logic [3:0]  rel, onehot;
        exp_t        e;
        last_rel = 0;
        forever begin
            @(posedge CLK);
            #1;
            rel = (wr | rd) & ~hlt;
            if (rel != 4'd0) begin
                if (q.size() == 0) begin
                    chk("unexpected_release", 64'(rel), 64'd0);
                end else begin
                    e = q.pop_front();
                    onehot = 4'b0001 << e.core;
                    chk("rel_core", 64'(rel), 64'(onehot));
                    chk("gnt", 64'(gnt), 64'(e.core));
                    chk("datai", 64'(datai), 64'(e.data));
                    chk("err", 64'(err), 64'(e.err));
                    if (e.gap > 0) chk("rel_gap", 64'(cyc - last_rel), 64'(e.gap));
                end
                last_rel = cyc;
            end
        end
    end

    initial begin : fx_mon
        int          last_rel;
        logic [3:0]  rel, onehot;
        exp_t        e;
        last_rel = 0;
        forever begin
            @(posedge CLK);
            #1;
            rel = (fx_wr | fx_rd) & ~fx_hlt;
            if (rel != 4'd0) begin
                if (fq.size() == 0) begin
                    chk("fx_unexpected_release", 64'(rel), 64'd0);
                end else begin
                    e = fq.pop_front();
                    onehot = 4'b0001 << e.core;
                    chk("fx_rel_core", 64'(rel), 64'(onehot));
                    chk("fx_gnt", 64'(fx_gnt), 64'(e.core));
                    chk("fx_datai", 64'(fx_datai), 64'(e.data));
                    chk("fx_hlt3", 64'(fx_hlt[3]), 64'd1);
                    if (e.gap > 0) chk("fx_rel_gap", 64'(cyc - last_rel), 64'(e.gap));
                end
                last_rel = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        RESn = 1'b0;
        wr = '0; rd = '0;
        mem_ready = 1'b1;
        resp_delay = 1;
        resp_xor = '0;
        for (int i = 0; i < 4; i++) begin
            daddr[32*i +: 32] = 32'h1000 * (i + 1);
            datao[32*i +: 32] = 32'hAAAA0000 + i;
        end
        be = 16'h3F51;
        fx_wr = '0; fx_rd = '0; fx_daddr = '0; fx_datao = '0; fx_be = '0;
        fx_mem_ready = 1'b1;
        fx_mem_data  = 32'h5A5A0000;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ref_valid", 64'(ref_valid), 64'd0);
        chk("rst_ref_rdwr", 64'({ref_rd, ref_wr}), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_datai", 64'(datai), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ref_addr", 64'(ref_addr), 64'd0);
        chk("rst_hlt", 64'(hlt), 64'd0);
        RESn = 1'b1;
        @(negedge CLK);

        // Round-robin with all cores reading: 0,1,2,3,0 at 4-cycle spacing
        rd = 4'b1111;
        push(0, 0, 32'h1000, 4'h0, 0);
        push(0, 1, 32'h2000, 4'h0, 4);
        push(0, 2, 32'h3000, 4'h0, 4);
        push(0, 3, 32'h4000, 4'h0, 4);
        push(0, 0, 32'h1000, 4'h0, 4);
        wait_q(0, 40, "rr_done");
        rd = '0;
        @(negedge CLK);

        // Write from core 2 with MEM_READY held low for 3 cycles
        daddr[64 +: 32] = 32'h100;
        datao[64 +: 32] = 32'h12345678;
        mem_ready = 1'b0;
        wr = 4'b0100;
        push(0, 2, 32'h100, 4'h0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("wr_ref_valid", 64'(ref_valid), 64'd1);
            chk("wr_ref_addr", 64'(ref_addr), 64'h100);
            chk("wr_ref_data", 64'(ref_data), 64'h12345678);
            chk("wr_ref_be", 64'(ref_be), 64'hF);
            chk("wr_ref_type", 64'({ref_wr, ref_rd}), 64'b10);
            chk("wr_gnt", 64'(gnt), 64'd2);
            if (c == 3) mem_ready = 1'b1;
        end
        @(negedge CLK);
        chk("wr_valid_dropped", 64'(ref_valid), 64'd0);
        wait_q(0, 10, "wr_done");
        @(negedge CLK);
        chk("wr_release_one_cycle", 64'(hlt), 64'b0100);
        wr = '0;
        @(negedge CLK);

        // Timeout: core 0 read, memory never answers
        resp_delay = 0;
        rd = 4'b0001;
        c0 = cyc;
        push(0, 0, 32'hDEADBEEF, 4'b0001, 0);
        wait_q(0, 20, "to_done");
        chk("to_latency", 64'(cyc - c0), 64'd10);
        @(negedge CLK);
        chk("to_err_one_cycle", 64'(err), 64'd0);
        rd = '0;
        @(negedge CLK);

        // Response on the same cycle the timeout would fire
        resp_delay = 8;
        resp_xor = 32'hA5A5A5A5 ^ 32'h2000;
        rd = 4'b0010;
        c0 = cyc;
        push(0, 1, 32'hA5A5A5A5, 4'h0, 0);
        wait_q(0, 20, "coin_done");
        chk("coin_latency", 64'(cyc - c0), 64'd10);
        rd = '0;
        resp_xor = '0;
        @(negedge CLK);

        // Reset during WAIT, then arbitration restarts from pointer 0
        resp_delay = 0;
        rd = 4'b0100;
        repeat (3) @(negedge CLK);
        rd = '0;
        RESn = 1'b0;
        #1;
        chk("mid_rst_ref_valid", 64'(ref_valid), 64'd0);
        chk("mid_rst_ref_rd", 64'(ref_rd), 64'd0);
        chk("mid_rst_gnt", 64'(gnt), 64'd0);
        chk("mid_rst_datai", 64'(datai), 64'd0);
        chk("mid_rst_ref_cmd", 64'({ref_addr, ref_data}), 64'd0);
        chk("mid_rst_ref_be", 64'(ref_be), 64'd0);
        chk("mid_rst_hlt_err", 64'({hlt, err}), 64'd0);
        @(negedge CLK);
        RESn = 1'b1;
        resp_delay = 1;
        rd = 4'b1100;
        push(0, 2, 32'h100, 4'h0, 0);
        push(0, 3, 32'h4000, 4'h0, 4);
        wait_q(0, 20, "post_rst_a");
        rd = 4'b1001;
        push(0, 0, 32'h1000, 4'h0, 4);
        wait_q(0, 20, "post_rst_b");
        rd = '0;
        @(negedge CLK);

        // Core 1 drops mid-transaction; core 3 waits, then completes
        resp_delay = 3;
        rd = 4'b0010;
        c0 = cyc;
        repeat (2) @(negedge CLK);
        rd = 4'b1000;
        push(0, 3, 32'h4000, 4'h0, 0);
        @(negedge CLK);
        chk("drop_hlt", 64'(hlt), 64'b1000);
        wait_q(0, 20, "drop_done");
        chk("drop_latency", 64'(cyc - c0), 64'd11);
        rd = '0;
        @(negedge CLK);

        // Fixed priority: cores 1 and 3 requesting, core 1 always wins
        fx_rd = 4'b1010;
        push(1, 1, 32'h5A5A0000, 4'h0, 0);
        push(1, 1, 32'h5A5A0000, 4'h0, 4);
        push(1, 1, 32'h5A5A0000, 4'h0, 4);
        wait_q(1, 30, "fx_done");
        fx_rd = '0;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
